// File: rtl/program_loader.sv
// program_loader: boot-stage image loader. Accepts a length-prefixed byte stream,
// packs little-endian 32-bit words into instruction memory from address 0,
// verifies a trailing XOR checksum and raises start (good) or error (bad).
module program_loader #(
    parameter int ADDR_WIDTH = 10   // at most 16: the image length field is 16 bits
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  start,
    output logic                  busy,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR
    } loaderState_e;

    // Largest legal word count, held one bit wider than the length field.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    loaderState_e state, nextState;

    logic        accept;
    logic [7:0]  lenHi;
    logic [15:0] lenWord;
    logic [15:0] wordsLeft;
    logic [1:0]  byteCnt;
    logic [23:0] wordBuf;
    logic [7:0]  xorAcc;

    assign accept  = rx_valid && rx_ready;
    assign lenWord = {lenHi, rx_data};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        nextState = state;
        rx_ready  = 1'b0;
        busy      = 1'b0;
        start     = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (load_req) nextState = LEN_HI;
            end
            DONE: begin
                start = 1'b1;
                if (load_req) nextState = LEN_HI;
            end
            ERROR: begin
                error = 1'b1;
                if (load_req) nextState = LEN_HI;
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) nextState = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    if (lenWord == 16'd0)                 nextState = CHECK;
                    else if ({1'b0, lenWord} > CAPACITY) nextState = ERROR;
                    else                                  nextState = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept && byteCnt == 2'd3 && wordsLeft == 16'd1) nextState = CHECK;
            end
            CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) nextState = (rx_data == xorAcc) ? DONE : ERROR;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: length capture, running checksum, word assembly and memory write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lenHi      <= '0;
            wordsLeft  <= '0;
            byteCnt    <= '0;
            wordBuf    <= '0;
            xorAcc     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            // The address advances at the end of the write cycle, so it is
            // stable for the whole cycle in which imem_we is high.
            if (imem_we) imem_addr <= imem_addr + ADDR_ONE;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (load_req) begin
                        xorAcc    <= '0;
                        byteCnt   <= '0;
                        imem_addr <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        lenHi  <= rx_data;
                        xorAcc <= xorAcc ^ rx_data;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        wordsLeft <= lenWord;
                        xorAcc    <= xorAcc ^ rx_data;
                    end
                end
                DATA: begin
                    if (accept) begin
                        xorAcc  <= xorAcc ^ rx_data;
                        byteCnt <= byteCnt + 2'd1;
                        case (byteCnt)
                            2'd0: wordBuf[7:0]   <= rx_data;
                            2'd1: wordBuf[15:8]  <= rx_data;
                            2'd2: wordBuf[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, wordBuf};
                                wordsLeft  <= wordsLeft - 16'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: table of image loads plus hand-written reset sequences.
module tb_program_loader;

    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic          load_req;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          start;
    logic          busy;
    logic          error;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .start      (start),
        .busy       (busy),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write monitor, sampled on the falling edge.
    logic [AW-1:0] wrAddr[$];
    logic [31:0]   wrData[$];
    logic          weLast    = 1'b0;
    int            weBackToBack = 0;
    int            bothHigh  = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wrAddr.push_back(imem_addr);
            wrData.push_back(imem_wdata);
            if (weLast) weBackToBack <= weBackToBack + 1;
        end
        if (start && error) bothHigh <= bothHigh + 1;
        weLast <= imem_we;
    end

    typedef struct {
        string        name;
        int           nBody;     // bytes from LEN_HI through last data byte
        logic [159:0] body;      // first byte in the most significant occupied position
        int           csMode;    // 0: no checksum byte, 1: correct XOR, 2: csByte
        logic [7:0]   csByte;
        int           nWrites;
        logic [127:0] words;     // word i at [32*(3-i) +: 32]
        logic         expStart;
        logic         expError;
        logic         gapped;    // random rx_valid gaps between bytes
        int           reqAt;     // byte index at which load_req is pulsed, -1 for none
    } loadVec_t;

    loadVec_t vecs[7];

    function automatic logic [7:0] byteOf(input loadVec_t v, input int i);
        return v.body[8*(v.nBody-1-i) +: 8];
    endfunction

    task automatic sendByte(input logic [7:0] b, input logic reqPulse, inout int notReady);
        if (reqPulse) load_req = 1'b1;
        if (!rx_ready) notReady++;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        load_req = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic runVec(input loadVec_t v);
        logic [7:0] b;
        logic [7:0] xorRef;
        int         notReady;
        int         total;
        xorRef   = 8'h00;
        notReady = 0;
        wrAddr.delete();
        wrData.delete();

        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        check({v.name, " busy after req"},     32'(busy),     32'd1);
        check({v.name, " rx_ready after req"}, 32'(rx_ready), 32'd1);
        check({v.name, " start cleared"},      32'(start),    32'd0);
        check({v.name, " error cleared"},      32'(error),    32'd0);

        total = v.nBody + ((v.csMode != 0) ? 1 : 0);
        for (int i = 0; i < total; i++) begin
            if (i < v.nBody) begin
                b = byteOf(v, i);
                xorRef ^= b;
            end else begin
                b = (v.csMode == 1) ? xorRef : v.csByte;
            end
            if (v.gapped) begin
                repeat ($urandom_range(0, 2)) begin
                    rx_valid = 1'b0;
                    rx_data  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            sendByte(b, (i == v.reqAt), notReady);
        end

        check({v.name, " start"},         32'(start),    32'(v.expStart));
        check({v.name, " error"},         32'(error),    32'(v.expError));
        check({v.name, " busy at end"},   32'(busy),     32'd0);
        check({v.name, " ready at end"},  32'(rx_ready), 32'd0);
        check({v.name, " never stalled"}, 32'(notReady), 32'd0);

        // Further traffic and idle cycles must not disturb the final result.
        repeat (3) begin
            rx_valid = 1'b1;
            rx_data  = 8'hA5;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        check({v.name, " start holds"}, 32'(start), 32'(v.expStart));
        check({v.name, " error holds"}, 32'(error), 32'(v.expError));

        check({v.name, " write count"}, 32'(wrAddr.size()), 32'(v.nWrites));
        for (int i = 0; i < v.nWrites && i < wrAddr.size(); i++) begin
            check($sformatf("%s addr[%0d]", v.name, i), 32'(wrAddr[i]), 32'(i));
            check($sformatf("%s data[%0d]", v.name, i), wrData[i], v.words[32*(3-i) +: 32]);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " rx_ready"},   32'(rx_ready),  32'd0);
        check({tag, " imem_we"},    32'(imem_we),   32'd0);
        check({tag, " imem_addr"},  32'(imem_addr), 32'd0);
        check({tag, " imem_wdata"}, imem_wdata,     32'd0);
        check({tag, " start"},      32'(start),     32'd0);
        check({tag, " busy"},       32'(busy),      32'd0);
        check({tag, " error"},      32'(error),     32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dummy;
        vecs[0] = '{"good2", 10,
                    160'({8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}),
                    1, 8'h00, 2, {32'h12345678, 32'hDEADBEEF, 64'h0}, 1'b1, 1'b0, 1'b0, -1};
        vecs[1] = '{"badcs", 10,
                    160'({8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}),
                    2, 8'h03, 2, {32'h12345678, 32'hDEADBEEF, 64'h0}, 1'b0, 1'b1, 1'b0, -1};
        vecs[2] = '{"empty", 2, 160'({8'h00, 8'h00}),
                    1, 8'h00, 0, 128'h0, 1'b1, 1'b0, 1'b0, -1};
        vecs[3] = '{"over5", 2, 160'({8'h00, 8'h05}),
                    0, 8'h00, 0, 128'h0, 1'b0, 1'b1, 1'b0, -1};
        vecs[4] = '{"over256", 2, 160'({8'h01, 8'h00}),
                    0, 8'h00, 0, 128'h0, 1'b0, 1'b1, 1'b0, -1};
        vecs[5] = '{"full4", 18,
                    160'({8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                          8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10}),
                    1, 8'h00, 4, {32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D},
                    1'b1, 1'b0, 1'b0, -1};
        vecs[6] = '{"gapped", 10,
                    160'({8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}),
                    1, 8'h00, 2, {32'h12345678, 32'hDEADBEEF, 64'h0}, 1'b1, 1'b0, 1'b1, 5};

        // Reset values, then release with rx_valid high and no request.
        reset    = 1'b0;
        load_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle rx_ready", 32'(rx_ready), 32'd0);
        check("idle busy",     32'(busy),     32'd0);
        check("idle writes",   32'(wrAddr.size()), 32'd0);
        rx_valid = 1'b0;

        for (int i = 0; i < 7; i++) runVec(vecs[i]);

        // Reset after the second data byte: asynchronous clear, no partial write.
        wrAddr.delete();
        wrData.delete();
        dummy = 0;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        sendByte(8'h00, 1'b0, dummy);
        sendByte(8'h02, 1'b0, dummy);
        sendByte(8'h78, 1'b0, dummy);
        sendByte(8'h56, 1'b0, dummy);
        #1 reset = 1'b0;
        #1;
        checkAllZero("midreset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("midreset no write", 32'(wrAddr.size()), 32'd0);
        check("midreset ready",    32'(rx_ready),      32'd0);
        runVec(vecs[0]);

        check("we single-cycle pulses", 32'(weBackToBack), 32'd0);
        check("start/error exclusive",  32'(bothHigh),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
